// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO between a bursty producer and the UART serialiser.
// First-word-fall-through read port, fill-level status and a sticky overflow flag.
module uart_tx_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_LVL = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              almost_full,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam logic [ADDR_W:0]   FULL_CNT  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_CNT = (ADDR_W+1)'(AFULL_LVL);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;

  logic w_push;
  logic w_pop;
  logic w_drop;

  // Status is decoded only from the registered count, so it never glitches mid-cycle.
  assign full        = (r_count == FULL_CNT);
  assign almost_full = (r_count >= AFULL_CNT);
  assign empty       = (r_count == '0);
  assign rd_valid    = ~empty;
  assign rd_data     = rd_valid ? r_mem[r_rd_ptr] : '0;
  assign count       = r_count;
  assign ovf         = r_ovf;

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_pop  = rd_valid & rd_ready;
  assign w_push = wr_en & (~full | w_pop);
  assign w_drop = wr_en & ~w_push;

  // NOTE: the storage array has no reset; rd_data is gated by rd_valid, so stale
  // contents are never visible, and leaving it unreset keeps it a plain register file.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: scoreboard queue of accepted bytes plus a
// small occupancy/overflow model, checked with immediate assertions.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       full, almost_full, rd_valid, empty, ovf;
  logic [7:0] rd_data;
  logic [4:0] count;

  logic [7:0] sb[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;
  int         n_chk = 0;
  int         n_pass = 0;

  uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .AFULL_LVL(12)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .almost_full(almost_full), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_ready(rd_ready), .count(count), .empty(empty), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Status and head checks against the model; called just after an edge has settled.
  task automatic chk_status();
    chk("count", 32'(count), 32'(m_cnt));
    chk("full", 32'(full), 32'(m_cnt == 16));
    chk("almost_full", 32'(almost_full), 32'(m_cnt >= 12));
    chk("empty", 32'(empty), 32'(m_cnt == 0));
    chk("rd_valid", 32'(rd_valid), 32'(m_cnt != 0));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    if (m_cnt == 0) chk("rd_data_idle", 32'(rd_data), 32'h0);
    else if (sb.size() != 0) chk("rd_data_head", 32'(rd_data), 32'(sb[0]));
  endtask

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic cyc(input logic we, input logic [7:0] wd, input logic rr, input logic clr);
    logic pop, push;
    wr_en = we; wr_data = wd; rd_ready = rr; ovf_clr = clr;
    #1;
    pop = rr && (m_cnt != 0);
    if (pop) begin
      if (sb.size() == 0) chk("sb_underflow", 32'(rd_data), 32'hFFFF_FFFF);
      else chk("pop_data", 32'(rd_data), 32'(sb.pop_front()));
    end
    push = we && ((m_cnt != 16) || pop);
    if (push) sb.push_back(wd);
    if (we && !push) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_cnt = m_cnt + int'(push) - int'(pop);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    chk_status();
  endtask

  initial begin
    // Reset then idle
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_status();
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_status();

    // Ordered drain of "Hello"
    cyc(1'b1, 8'h48, 1'b0, 1'b0);
    cyc(1'b1, 8'h65, 1'b0, 1'b0);
    cyc(1'b1, 8'h6C, 1'b0, 1'b0);
    cyc(1'b1, 8'h6C, 1'b0, 1'b0);
    cyc(1'b1, 8'h6F, 1'b0, 1'b0);
    chk("hello_count", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) begin
      repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("hello_empty", 32'(empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);   // rd_ready while empty has no effect

    // Fill and overflow
    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 15) chk("full_after_16", 32'(full), 32'd1);
    end
    chk("ovf_after_drop", 32'(ovf), 32'd1);
    cyc(1'b1, 8'h99, 1'b0, 1'b1);   // drop and clear together: set wins
    chk("ovf_set_wins", 32'(ovf), 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_sticky", 32'(ovf), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // Simultaneous push/pop while full
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk("head_zero", 32'(rd_data), 32'h00);
    cyc(1'b1, 8'hAA, 1'b1, 1'b0);
    chk("full_pushpop_count", 32'(count), 32'd16);
    chk("full_pushpop_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap with occupancy held between 3 and 6
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      case (i % 8)
        0, 1:    cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        4, 5:    cyc(1'b0, 8'h00, 1'b1, 1'b0);
        default: cyc(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
      endcase
      chk("wrap_range", 32'(count >= 5'd3 && count <= 5'd6), 32'd1);
    end
    while (m_cnt != 0) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset mid-stream
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("pre_reset_count", 32'(count), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    sb.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1'b1, 8'h55, 1'b0, 1'b0);
    chk("post_rst_data", 32'(rd_data), 32'h55);
    chk("post_rst_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer sitting directly upstream of the UART transmitter serialiser.
- A producer (CPU store path or test logic) pushes bytes at clock rate; the transmitter pops one byte per serial frame using a valid/ready handshake.
- Decouples bursty writes from the slow 115200-baud line.
- Provides fill-level status and a sticky overflow flag for software polling.

Parameters:
- DATA_W, 8, width of one entry in bits.
- DEPTH, 16, number of entries; must be a power of 2, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.
- AFULL_LVL, 12, count at or above which almost_full asserts; range 1..DEPTH.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  push request, sampled on posedge clk.
- wr_data  in  DATA_W  byte to push.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AFULL_LVL.
- rd_valid  out  1  head entry available (count != 0).
- rd_data  out  DATA_W  head entry, first-word-fall-through; forced 0 when rd_valid=0.
- rd_ready  in  1  consumer accepts head this cycle.
- count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- empty  out  1  count == 0.
- ovf  out  1  sticky: a push was dropped.
- ovf_clr  in  1  clears ovf.

Behaviour:
- Reset (asynchronous assert, synchronous release on clk): wr_ptr=0, rd_ptr=0, count=0, ovf=0.
  - Outputs during reset: empty=1, rd_valid=0, rd_data=0, full=0, almost_full=0.
  - Storage array is not reset.
- Reset mid-operation discards all contents immediately. rd_valid drops in the same cycle reset asserts.
- Storage: DEPTH x DATA_W register array.
  - Write: synchronous.
  - Read: combinational from mem[rd_ptr].
- pop = rd_valid & rd_ready.
  - On pop, rd_ptr increments modulo DEPTH (natural ADDR_W wrap).
  - rd_ready while empty has no effect.
- push = wr_en & (~full | pop).
  - On push, mem[wr_ptr] <= wr_data and wr_ptr increments modulo DEPTH.
  - A write to a full FIFO is accepted if a pop occurs in the same cycle.
- count update:
  - push only: +1.
  - pop only: -1.
  - both, or neither: unchanged.
  - count never exceeds DEPTH and never underflows.
- Write latency: a byte pushed into an empty FIFO appears on rd_data with rd_valid=1 on the next cycle. No same-cycle bypass.
- Order is strict FIFO.
- rd_data is stable while rd_valid=1 and rd_ready=0, i.e. the head holds until popped.
- Overflow: if wr_en=1, full=1 and no pop that cycle, the byte is dropped.
  - Pointers and count are unchanged.
  - ovf <= 1 on the next edge.
  - If ovf_clr and a drop occur in the same cycle, set wins (ovf stays 1).
  - Otherwise ovf_clr clears ovf on the next edge.
- Status outputs (full, almost_full, empty, rd_valid) are decoded combinationally from registered count, so they are glitch-free relative to clk.
- Consumer contract (transmitter): assert rd_ready for exactly one cycle when loading the shift register. The popped byte is rd_data in that cycle.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release -> count=0, empty=1, rd_valid=0, rd_data=0x00, ovf=0.
- Ordered drain: push 0x48,0x65,0x6C,0x6C,0x6F on consecutive cycles, then rd_ready=1 every 5th cycle -> pops return "Hello" in order; count goes 5→0; empty=1 after the last pop.
- Fill and overflow: push 17 bytes 0x00..0x10 with rd_ready=0 -> full=1 after the 16th push; almost_full=1 from count=12; 0x10 dropped; ovf=1; pops then return 0x00..0x0F; ovf stays 1 until ovf_clr=1 for one cycle.
- Simultaneous push/pop when full: FIFO full with head 0x00, assert wr_en=1 (wr_data=0xAA) and rd_ready=1 for one cycle -> count stays 16, ovf stays 0; 0xAA is returned as the 16th subsequent pop.
- Pointer wrap: run 40 push/pop pairs of incrementing data while holding count between 3 and 6 -> every popped byte matches the scoreboard; count never goes out of range.
- Reset mid-stream: with count=7, pulse rst_n low asynchronously between edges -> empty=1 and rd_valid=0 immediately; after release, push 0x55 -> next-cycle rd_data=0x55 and count=1.
